// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - registered RV32I decode stage with load-use stall and ID branch resolution
module id_stage_pipe #(
    parameter int XLEN         = 32,
    parameter int REG_AW       = 5,
    parameter int BRANCH_IN_ID = 1,
    parameter int HAZARD_CHECK = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [31:0]       inst_i,
    output logic [REG_AW-1:0] rs1_addr_o,
    output logic [REG_AW-1:0] rs2_addr_o,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [2:0]        out_class_o,
    output logic [2:0]        out_funct3_o,
    output logic              out_alt_o,
    output logic [XLEN-1:0]   out_op1_o,
    output logic [XLEN-1:0]   out_op2_o,
    output logic [XLEN-1:0]   out_imm_o,
    output logic [XLEN-1:0]   out_sdata_o,
    output logic [REG_AW-1:0] out_rd_o,
    output logic              out_wreg_o,
    output logic              out_illegal_o,
    output logic              redirect_o,
    output logic [XLEN-1:0]   redirect_addr_o
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] CLS_NOP    = 3'd0;
    localparam logic [2:0] CLS_ALU    = 3'd1;
    localparam logic [2:0] CLS_LOAD   = 3'd2;
    localparam logic [2:0] CLS_STORE  = 3'd3;
    localparam logic [2:0] CLS_BRANCH = 3'd4;
    localparam logic [2:0] CLS_JUMP   = 3'd5;
    localparam logic [2:0] CLS_UPPER  = 3'd6;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [REG_AW-1:0] rd;

    logic signed [11:0] i12;
    logic signed [11:0] s12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    logic signed [31:0] u32;
    logic [XLEN-1:0]    imm_i, imm_s, imm_b, imm_j, imm_u;

    assign opcode     = inst_i[6:0];
    assign funct3     = inst_i[14:12];
    assign rd         = REG_AW'(inst_i[11:7]);
    assign rs1_addr_o = REG_AW'(inst_i[19:15]);
    assign rs2_addr_o = REG_AW'(inst_i[24:20]);

    // Signed intermediates so the size casts sign-extend to XLEN.
    assign i12   = inst_i[31:20];
    assign s12   = {inst_i[31:25], inst_i[11:7]};
    assign b13   = {inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign j21   = {inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    assign u32   = {inst_i[31:12], 12'b0};
    assign imm_i = XLEN'(i12);
    assign imm_s = XLEN'(s12);
    assign imm_b = XLEN'(b13);
    assign imm_j = XLEN'(j21);
    assign imm_u = XLEN'(u32);

    logic [2:0]      d_class;
    logic [XLEN-1:0] d_op1, d_op2, d_imm, d_target;
    logic            d_writes, d_illegal, d_alt, d_redirect;
    logic            uses_rs1, uses_rs2, br_cond;

    always_comb begin
        case (funct3)
            3'b000:  br_cond = (rs1_data_i == rs2_data_i);
            3'b001:  br_cond = (rs1_data_i != rs2_data_i);
            3'b100:  br_cond = ($signed(rs1_data_i) <  $signed(rs2_data_i));
            3'b101:  br_cond = ($signed(rs1_data_i) >= $signed(rs2_data_i));
            3'b110:  br_cond = (rs1_data_i <  rs2_data_i);
            3'b111:  br_cond = (rs1_data_i >= rs2_data_i);
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        d_class    = CLS_NOP;
        d_op1      = '0;
        d_op2      = '0;
        d_imm      = '0;
        d_target   = '0;
        d_writes   = 1'b0;
        d_illegal  = 1'b0;
        d_alt      = 1'b0;
        d_redirect = 1'b0;
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        case (opcode)
            OPC_LUI: begin
                d_class  = CLS_UPPER;
                d_op2    = imm_u;
                d_imm    = imm_u;
                d_writes = 1'b1;
            end
            OPC_AUIPC: begin
                d_class  = CLS_UPPER;
                d_op1    = pc_i;
                d_op2    = imm_u;
                d_imm    = imm_u;
                d_writes = 1'b1;
            end
            OPC_JAL: begin
                d_class    = CLS_JUMP;
                d_op1      = pc_i;
                d_op2      = XLEN'(4);
                d_imm      = imm_j;
                d_writes   = 1'b1;
                d_redirect = 1'b1;
                d_target   = pc_i + imm_j;
            end
            OPC_JALR: begin
                d_class    = CLS_JUMP;
                d_op1      = pc_i;
                d_op2      = XLEN'(4);
                d_imm      = imm_i;
                d_writes   = 1'b1;
                uses_rs1   = 1'b1;
                d_redirect = 1'b1;
                d_target   = (rs1_data_i + imm_i) & {{(XLEN-1){1'b1}}, 1'b0};
            end
            OPC_BRANCH: begin
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    d_illegal = 1'b1;
                end else begin
                    d_class    = CLS_BRANCH;
                    d_op1      = rs1_data_i;
                    d_op2      = rs2_data_i;
                    d_imm      = imm_b;
                    uses_rs1   = 1'b1;
                    uses_rs2   = 1'b1;
                    d_redirect = br_cond;
                    d_target   = pc_i + imm_b;
                end
            end
            OPC_LOAD: begin
                d_class  = CLS_LOAD;
                d_op1    = rs1_data_i;
                d_op2    = imm_i;
                d_imm    = imm_i;
                d_writes = 1'b1;
                uses_rs1 = 1'b1;
            end
            OPC_STORE: begin
                d_class  = CLS_STORE;
                d_op1    = rs1_data_i;
                d_op2    = imm_s;
                d_imm    = imm_s;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_OPIMM: begin
                d_class  = CLS_ALU;
                d_op1    = rs1_data_i;
                d_op2    = imm_i;
                d_imm    = imm_i;
                d_writes = 1'b1;
                d_alt    = (funct3 == 3'b101) ? inst_i[30] : 1'b0;
                uses_rs1 = 1'b1;
            end
            OPC_OP: begin
                d_class  = CLS_ALU;
                d_op1    = rs1_data_i;
                d_op2    = rs2_data_i;
                d_writes = 1'b1;
                d_alt    = inst_i[30];
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            default: d_illegal = 1'b1;
        endcase
    end

    logic              last_load_q;
    logic [REG_AW-1:0] last_load_rd_q;
    logic              hit_out, hit_last, hazard, accept, load_handoff;

    // Only a source the incoming instruction really reads can create a stall.
    assign hit_out  = (out_rd_o != '0) &&
                      ((uses_rs1 && out_rd_o == rs1_addr_o) || (uses_rs2 && out_rd_o == rs2_addr_o));
    assign hit_last = (last_load_rd_q != '0) &&
                      ((uses_rs1 && last_load_rd_q == rs1_addr_o) ||
                       (uses_rs2 && last_load_rd_q == rs2_addr_o));
    assign hazard   = (HAZARD_CHECK != 0) &&
                      ((out_valid_o && out_class_o == CLS_LOAD && hit_out) || (last_load_q && hit_last));

    assign in_ready_o   = !rst && !flush_i && !redirect_o && !hazard && (!out_valid_o || out_ready_i);
    assign accept       = in_valid_i && in_ready_o;
    assign load_handoff = (HAZARD_CHECK != 0) && out_valid_o && out_ready_i && out_class_o == CLS_LOAD;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_o     <= 1'b0;
            out_class_o     <= '0;
            out_funct3_o    <= '0;
            out_alt_o       <= 1'b0;
            out_op1_o       <= '0;
            out_op2_o       <= '0;
            out_imm_o       <= '0;
            out_sdata_o     <= '0;
            out_rd_o        <= '0;
            out_wreg_o      <= 1'b0;
            out_illegal_o   <= 1'b0;
            redirect_o      <= 1'b0;
            redirect_addr_o <= '0;
            last_load_q     <= 1'b0;
            last_load_rd_q  <= '0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
            last_load_q <= 1'b0;
            redirect_o  <= 1'b0;
        end else begin
            last_load_q <= load_handoff;
            if (load_handoff) begin
                last_load_rd_q <= out_rd_o;
            end
            redirect_o <= accept && d_redirect && (BRANCH_IN_ID != 0);
            if (accept && d_redirect && (BRANCH_IN_ID != 0)) begin
                redirect_addr_o <= d_target;
            end
            if (accept) begin
                out_valid_o   <= 1'b1;
                out_class_o   <= d_class;
                out_funct3_o  <= funct3;
                out_alt_o     <= d_alt;
                out_op1_o     <= d_op1;
                out_op2_o     <= d_op2;
                out_imm_o     <= d_imm;
                out_sdata_o   <= rs2_data_i;
                out_rd_o      <= rd;
                out_wreg_o    <= d_writes && (rd != '0);
                out_illegal_o <= d_illegal;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - directed-vector bench for id_stage_pipe
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic [4:0]  rs1_addr_o, rs2_addr_o;
    logic [31:0] rs1_data_i, rs2_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [2:0]  out_class_o, out_funct3_o;
    logic        out_alt_o;
    logic [31:0] out_op1_o, out_op2_o, out_imm_o, out_sdata_o;
    logic [4:0]  out_rd_o;
    logic        out_wreg_o, out_illegal_o, redirect_o;
    logic [31:0] redirect_addr_o;

    logic [31:0] rf [32];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign rs1_data_i = (rs1_addr_o == 5'd0) ? 32'd0 : rf[rs1_addr_o];
    assign rs2_data_i = (rs2_addr_o == 5'd0) ? 32'd0 : rf[rs2_addr_o];

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .pc_i(pc_i), .inst_i(inst_i),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_class_o(out_class_o), .out_funct3_o(out_funct3_o), .out_alt_o(out_alt_o),
        .out_op1_o(out_op1_o), .out_op2_o(out_op2_o), .out_imm_o(out_imm_o),
        .out_sdata_o(out_sdata_o), .out_rd_o(out_rd_o), .out_wreg_o(out_wreg_o),
        .out_illegal_o(out_illegal_o), .redirect_o(redirect_o),
        .redirect_addr_o(redirect_addr_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        in_valid_i = v;
        pc_i       = pc;
        inst_i     = inst;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rst = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0;
        drive(1'b0, 32'd0, 32'd0);
        step(); step();
        #1;
        check("rst_in_ready", in_ready_o, 0);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_redirect", redirect_o, 0);
        check("rst_op1", out_op1_o, 0);
        rst = 1'b0;
        out_ready_i = 1'b1;

        // addi x1,x0,5
        step();
        drive(1'b1, 32'h0, 32'h00500093);
        #1 check("addi_in_ready", in_ready_o, 1);
        step();
        drive(1'b0, 32'h0, 32'h0);
        check("addi_valid", out_valid_o, 1);
        check("addi_class", out_class_o, 1);
        check("addi_op1", out_op1_o, 0);
        check("addi_op2", out_op2_o, 5);
        check("addi_rd", out_rd_o, 1);
        check("addi_wreg", out_wreg_o, 1);
        step();
        check("addi_drain", out_valid_o, 0);

        // lw x2,0(x1) then dependent add x3,x2,x2
        rf[1] = 32'h10; rf[2] = 32'h33;
        drive(1'b1, 32'h4, 32'h0000A103);
        #1 check("lw_in_ready", in_ready_o, 1);
        step();
        drive(1'b1, 32'h8, 32'h002101B3);
        #1 check("lu_stall1", in_ready_o, 0);
        check("lw_class", out_class_o, 2);
        check("lw_op1", out_op1_o, 32'h10);
        check("lw_rd", out_rd_o, 2);
        step();
        #1 check("lu_stall2", in_ready_o, 0);
        check("lu_gap_valid", out_valid_o, 0);
        step();
        #1 check("add_accept", in_ready_o, 1);
        step();
        drive(1'b0, 32'h0, 32'h0);
        check("add_class", out_class_o, 1);
        check("add_op1", out_op1_o, 32'h33);
        check("add_op2", out_op2_o, 32'h33);
        check("add_rd", out_rd_o, 3);

        // beq x1,x2,+8 taken, with a wrong-path instruction offered during redirect
        rf[1] = 32'd7; rf[2] = 32'd7;
        step();
        drive(1'b1, 32'h100, 32'h00208463);
        #1 check("beq_in_ready", in_ready_o, 1);
        step();
        drive(1'b1, 32'h104, 32'h00500093);
        #1 check("beq_redirect", redirect_o, 1);
        check("beq_addr", redirect_addr_o, 32'h108);
        check("beq_squash_ready", in_ready_o, 0);
        check("beq_class", out_class_o, 4);
        check("beq_wreg", out_wreg_o, 0);
        check("beq_imm", out_imm_o, 8);
        step();
        drive(1'b0, 32'h0, 32'h0);
        check("beq_pulse_end", redirect_o, 0);
        check("beq_wrongpath_dropped", out_valid_o, 0);

        // beq not taken
        rf[2] = 32'd8;
        drive(1'b1, 32'h100, 32'h00208463);
        step();
        drive(1'b0, 32'h0, 32'h0);
        check("bne_no_redirect", redirect_o, 0);
        check("bnt_valid", out_valid_o, 1);

        // jalr x1,3(x5)
        rf[5] = 32'h200;
        step();
        drive(1'b1, 32'h40, 32'h003280E7);
        step();
        drive(1'b0, 32'h0, 32'h0);
        check("jalr_redirect", redirect_o, 1);
        check("jalr_addr", redirect_addr_o, 32'h202);
        check("jalr_op1", out_op1_o, 32'h40);
        check("jalr_op2", out_op2_o, 4);
        check("jalr_rd", out_rd_o, 1);
        check("jalr_wreg", out_wreg_o, 1);
        check("jalr_class", out_class_o, 5);

        // sw x2,-4(x1)
        step();
        drive(1'b1, 32'h44, 32'hFE20AE23);
        step();
        drive(1'b0, 32'h0, 32'h0);
        check("sw_class", out_class_o, 3);
        check("sw_op1", out_op1_o, 32'd7);
        check("sw_op2", out_op2_o, 32'hFFFFFFFC);
        check("sw_sdata", out_sdata_o, 32'd8);
        check("sw_wreg", out_wreg_o, 0);

        // back-pressure: addi x4,x0,9 held for 3 cycles, then addi x5,x0,-1 handed in
        step();
        out_ready_i = 1'b0;
        drive(1'b1, 32'h50, 32'h00900213);
        #1 check("bp_accept", in_ready_o, 1);
        step();
        drive(1'b1, 32'h54, 32'hFFF00293);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) step();
            #1;
            check("bp_valid", out_valid_o, 1);
            check("bp_op2", out_op2_o, 9);
            check("bp_rd", out_rd_o, 4);
            check("bp_in_ready", in_ready_o, 0);
        end
        out_ready_i = 1'b1;
        #1 check("bp_release_ready", in_ready_o, 1);
        step();
        drive(1'b0, 32'h0, 32'h0);
        check("bp_next_valid", out_valid_o, 1);
        check("bp_next_op2", out_op2_o, 32'hFFFFFFFF);
        check("bp_next_rd", out_rd_o, 5);

        // illegal opcode, then flush during a stall
        step();
        drive(1'b1, 32'h60, 32'hFFFFFFFF);
        step();
        drive(1'b0, 32'h0, 32'h0);
        out_ready_i = 1'b0;
        check("ill_flag", out_illegal_o, 1);
        check("ill_class", out_class_o, 0);
        check("ill_wreg", out_wreg_o, 0);
        check("ill_valid", out_valid_o, 1);
        step();
        check("ill_hold", out_valid_o, 1);
        flush_i = 1'b1;
        #1 check("flush_in_ready", in_ready_o, 0);
        step();
        flush_i = 1'b0;
        check("flush_valid", out_valid_o, 0);

        // reset pulse mid-stall
        drive(1'b1, 32'h70, 32'h00500093);
        step();
        drive(1'b0, 32'h0, 32'h0);
        check("prerst_valid", out_valid_o, 1);
        rst = 1'b1;
        #1 check("rst_hi_ready", in_ready_o, 0);
        step();
        check("midrst_valid", out_valid_o, 0);
        check("midrst_op2", out_op2_o, 0);
        check("midrst_rd", out_rd_o, 0);
        check("midrst_wreg", out_wreg_o, 0);
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
